multi_rate_tick_gen: RTL

Parametrised successor to the single-rate sample tick driver. It generates N_CH independent fractional-rate tick streams from one system clock, using one phase accumulator per channel. Each channel's rate can be reprogrammed at runtime through a valid/ready config port, and new rates take effect glitch-free at that channel's next tick. It feeds the oscillator and audio-output blocks, which need differing or switchable sample rates.

---
 rtl/tick_gen_pkg.sv | 19 +
 rtl/tick_accumulator.sv | 98 +++++++++
 rtl/multi_rate_tick_gen.sv | 77 +++++++
 3 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants, types and helpers for the multi-rate tick generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tick_gen_pkg;

  localparam int CLK_FREQ_DEFAULT = 12_000_000;
  localparam int FS_DEFAULT       = 48_000;

  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_e;

  // Wide enough for acc + rate with acc < clk_freq and rate < 2**rate_w.
  function automatic int acc_width(input longint clk_freq, input int rate_w);
    return $clog2(clk_freq + (longint'(1) << rate_w));
  endfunction

endpackage

// File: rtl/tick_accumulator.sv
// One fractional-rate tick channel: phase accumulator, active/shadow rate, pending FSM.
// Latency: tick registered, one cycle after the wrap decision.
// Backpressure: load_vld is only honoured while idle; pending blocks further loads upstream.
module tick_accumulator
  import tick_gen_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DEFAULT,
  parameter int RATE_W    = 20,
  parameter int ACC_W     = 24,
  parameter int RATE_INIT = FS_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic              load_vld,
  input  logic [RATE_W-1:0] load_rate,
  output logic              pending,
  output logic              tick
`ifdef TICK_PHASE_EN
  ,
  output logic [ACC_W-1:0]  acc_dat
`endif
);

  localparam logic [ACC_W-1:0]  CLK_A    = ACC_W'(CLK_FREQ);
  localparam logic [RATE_W-1:0] RATE_RST = RATE_W'(RATE_INIT);

  cfg_state_e        state_q, state_d;
  logic [RATE_W-1:0] rate_q, rate_d, shadow_q;
  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic              tick_q, tick_d, wrap, apply;

  // Accumulator step in priority order: sync, hold, wrap, advance
  always_comb begin
    sum    = acc_q + ACC_W'(rate_q);
    wrap   = (sum >= CLK_A);
    acc_d  = acc_q;
    tick_d = 1'b0;
    apply  = 1'b0;
    if (sync_i) begin
      acc_d = '0;
      apply = 1'b1;
    end else if (!en_i) begin
      // No tick will come while stopped, so a pending rate lands right away.
      apply = 1'b1;
    end else if (wrap) begin
      tick_d = 1'b1;
      acc_d  = sum - CLK_A;
      apply  = 1'b1;
    end else begin
      acc_d = sum;
    end
  end

  // Pending FSM: a load made this cycle is only visible from next cycle,
  // so a load coinciding with a wrap or sync waits for the following event
  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    case (state_q)
      CFG_IDLE: begin
        if (load_vld) state_d = CFG_PENDING;
      end
      CFG_PENDING: begin
        if (apply) begin
          state_d = CFG_IDLE;
          rate_d  = shadow_q;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  // State, rate, shadow, accumulator and tick registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= CFG_IDLE;
      rate_q   <= RATE_RST;
      shadow_q <= RATE_RST;
      acc_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      acc_q   <= acc_d;
      tick_q  <= tick_d;
      if (load_vld && state_q == CFG_IDLE) shadow_q <= load_rate;
    end
  end

  assign pending = (state_q == CFG_PENDING);
  assign tick    = tick_q;
`ifdef TICK_PHASE_EN
  assign acc_dat = acc_q;
`endif

endmodule

// File: rtl/multi_rate_tick_gen.sv
// N_CH independent fractional-rate tick streams with runtime rate reprogramming.
// Latency: ticks one cycle after the wrap decision; cfg_err_o one cycle after a rejected accept.
// Backpressure: cfg_ready_o low while the addressed channel holds a pending rate. Option: TICK_PHASE_EN adds phase_o.
module multi_rate_tick_gen #(
  parameter int  CLK_FREQ   = tick_gen_pkg::CLK_FREQ_DEFAULT,
  parameter int  N_CH       = 2,
  parameter int  RATE_W     = 20,
  parameter int  FS_DEFAULT = tick_gen_pkg::FS_DEFAULT,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int ACC_W      = tick_gen_pkg::acc_width(CLK_FREQ, RATE_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [RATE_W-1:0] cfg_rate_i,
  output logic              cfg_err_o,
  output logic [N_CH-1:0]   tick_o
`ifdef TICK_PHASE_EN
  ,
  output logic [N_CH*ACC_W-1:0] phase_o
`endif
);

  import tick_gen_pkg::*;

  logic [N_CH-1:0] pending;
  logic            cfg_ready, cfg_accept, cfg_ok, cfg_err_q;

  // Ready follows the addressed channel; unknown channels always accept so they can be rejected
  always_comb begin
    cfg_ready = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (cfg_ch_i == CH_W'(c)) cfg_ready = !pending[c];
    end
  end

  assign cfg_ready_o = cfg_ready;
  assign cfg_accept  = cfg_valid_i && cfg_ready;
  assign cfg_ok      = (cfg_rate_i != '0)
                    && (ACC_W'(cfg_rate_i) < ACC_W'(CLK_FREQ))
                    && (int'(cfg_ch_i) < N_CH);

  // Rejected requests still complete the handshake; flag them one cycle later
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cfg_err_q <= 1'b0;
    else       cfg_err_q <= cfg_accept && !cfg_ok;
  end

  assign cfg_err_o = cfg_err_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    tick_accumulator #(
      .CLK_FREQ  (CLK_FREQ),
      .RATE_W    (RATE_W),
      .ACC_W     (ACC_W),
      .RATE_INIT (FS_DEFAULT)
    ) u_acc (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .sync_i    (sync_i),
      .load_vld  (cfg_accept && cfg_ok && (cfg_ch_i == CH_W'(c))),
      .load_rate (cfg_rate_i),
      .pending   (pending[c]),
      .tick      (tick_o[c])
`ifdef TICK_PHASE_EN
      ,
      .acc_dat   (phase_o[c*ACC_W +: ACC_W])
`endif
    );
  end

endmodule
